sseg_bcd_display: RTL and testbench



---
 rtl/sseg_pkg.sv | 34 +++
 rtl/sseg_bcd_display_if.sv | 23 ++
 rtl/bin2bcd_seq.sv | 73 +++++++
 rtl/sseg_bcd_display.sv | 101 ++++++++++
 tb/tb_sseg_bcd_display.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/sseg_pkg.sv
// Shared types, limits and the seven-segment decode table for the BCD display stage.
package sseg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } conv_state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam int unsigned MAX_VAL  = 9999;

  // Active-low segments {CG,CF,CE,CD,CC,CB,CA}; non-decimal codes render blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    seg = 7'h7F;
    case (digit)
      4'd0: seg = 7'h40;
      4'd1: seg = 7'h79;
      4'd2: seg = 7'h24;
      4'd3: seg = 7'h30;
      4'd4: seg = 7'h19;
      4'd5: seg = 7'h12;
      4'd6: seg = 7'h02;
      4'd7: seg = 7'h78;
      4'd8: seg = 7'h00;
      4'd9: seg = 7'h10;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sseg_bcd_display_if.sv
// Load handshake, display controls and display pins of the BCD display stage.
interface sseg_bcd_display_if;

  logic [13:0] bin_in;
  logic        bin_valid;
  logic        ready;
  logic        blank_lz;
  logic [7:0]  dp_mask;
  logic        ovf;
  logic [7:0]  AN;
  logic [7:0]  SEG;

  modport master (
    output bin_in, bin_valid, blank_lz, dp_mask,
    input  ready, ovf, AN, SEG
  );

  modport slave (
    input  bin_in, bin_valid, blank_lz, dp_mask,
    output ready, ovf, AN, SEG
  );

endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: 14-bit binary to four BCD digits, one bit per cycle.
module bin2bcd_seq
  import sseg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        ready,
  output logic        done,
  output logic [15:0] bcd
);

  conv_state_t state, state_nxt;
  logic [29:0] shreg;
  logic [3:0]  cnt;

  function automatic logic [15:0] dabble(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int n = 0; n < 4; n++) begin
      if (r[4*n +: 4] >= 4'd5) r[4*n +: 4] = r[4*n +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = LOAD;
      end
      LOAD:  state_nxt = SHIFT;
      SHIFT: if (cnt == 4'd1) state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE:  if (start) shreg[13:0] <= bin;
        LOAD: begin
          shreg[29:14] <= '0;
          cnt          <= 4'd14;
        end
        SHIFT: begin
          shreg <= {dabble(shreg[29:14]), shreg[13:0]} << 1;
          cnt   <= cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign bcd = shreg[29:14];

endmodule

// File: rtl/sseg_bcd_display.sv
// Saturating load, BCD conversion, committed digit registers and a 4-digit multiplexed
// seven-segment scanner with leading-zero blanking and per-digit decimal points.
module sseg_bcd_display #(
  parameter int unsigned SCAN_DIV = 100_000,
  parameter int unsigned MAX_VAL  = 9999
) (
  input  logic                CLK100MHZ,
  input  logic                RST,
  sseg_bcd_display_if.slave   bus
);
  import sseg_pkg::*;

  localparam int unsigned DW      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [13:0]   MAX14    = 14'(MAX_VAL);

  logic        conv_ready;
  logic        conv_done;
  logic [15:0] conv_bcd;
  logic        accept;
  logic        sat;
  logic [13:0] bin_sat;
  logic        ovf_pend;
  logic        ovf_q;
  logic [15:0] digits;

  logic [DW-1:0] div;
  logic [1:0]    idx;
  logic [3:0]    cur_digit;
  logic          cur_blank;
  logic [7:0]    an_q;
  logic [7:0]    seg_q;

  assign sat     = (bus.bin_in > MAX14);
  assign bin_sat = sat ? MAX14 : bus.bin_in;
  assign accept  = bus.bin_valid && conv_ready;

  bin2bcd_seq u_bin2bcd (
    .clk   (CLK100MHZ),
    .rst   (RST),
    .start (bus.bin_valid),
    .bin   (bin_sat),
    .ready (conv_ready),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Digits and ovf only move at DONE, so the display never shows a partial conversion.
  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      ovf_pend <= 1'b0;
      ovf_q    <= 1'b0;
      digits   <= '0;
    end else begin
      if (accept)    ovf_pend <= sat;
      if (conv_done) begin
        digits <= conv_bcd;
        ovf_q  <= ovf_pend;
      end
    end
  end

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      div <= '0;
      idx <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
      idx <= idx + 2'd1;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_comb begin
    cur_digit = digits[4*idx +: 4];
    cur_blank = 1'b0;
    case (idx)
      2'd1: cur_blank = bus.blank_lz && (digits[15:4]  == 12'd0);
      2'd2: cur_blank = bus.blank_lz && (digits[15:8]  == 8'd0);
      2'd3: cur_blank = bus.blank_lz && (digits[15:12] == 4'd0);
      default: cur_blank = 1'b0;
    endcase
  end

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      an_q  <= 8'hFF;
      seg_q <= SEG_BLANK;
    end else begin
      an_q  <= {4'hF, ~(4'b0001 << idx)};
      seg_q <= {~bus.dp_mask[{1'b0, idx}], cur_blank ? SEG_BLANK[6:0] : seg_decode(cur_digit)};
    end
  end

  assign bus.ready = conv_ready;
  assign bus.ovf   = ovf_q;
  assign bus.AN    = an_q;
  assign bus.SEG   = seg_q;

endmodule

// File: tb/tb_sseg_bcd_display.sv
// Directed bench for sseg_bcd_display with SCAN_DIV=4 and hand-computed segment codes.
module tb_sseg_bcd_display;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  sseg_bcd_display_if bus ();

  sseg_bcd_display #(.SCAN_DIV(4), .MAX_VAL(9999)) dut (
    .CLK100MHZ (clk),
    .RST       (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the scanner to present slot 'an', then checks its segments.
  task automatic wait_slot(input logic [7:0] an, input logic [7:0] seg, input string tag);
    logic found;
    found = 1'b0;
    tick();
    for (int i = 0; i < 16 && !found; i++) begin
      if (bus.AN === an) found = 1'b1;
      else tick();
    end
    check({tag, "_slot_seen"}, {7'd0, found}, 8'd1);
    if (found) check({tag, "_seg"}, bus.SEG, seg);
  endtask

  // Accepts v at cycle 0; optionally offers 42 during cycle drop_at, which must be ignored.
  task automatic do_load(input logic [13:0] v, input int drop_at, input string tag);
    bus.bin_in    = v;
    bus.bin_valid = 1'b1;
    tick();
    bus.bin_valid = 1'b0;
    check({tag, "_ready_c1"}, {7'd0, bus.ready}, 8'd0);
    for (int c = 1; c < 16; c++) begin
      if (c == drop_at) begin
        bus.bin_in    = 14'd42;
        bus.bin_valid = 1'b1;
      end else begin
        bus.bin_valid = 1'b0;
      end
      tick();
    end
    bus.bin_valid = 1'b0;
    check({tag, "_ready_c16"}, {7'd0, bus.ready}, 8'd0);
    tick();
    check({tag, "_ready_c17"}, {7'd0, bus.ready}, 8'd1);
  endtask

  initial begin
    bus.bin_in    = '0;
    bus.bin_valid = 1'b0;
    bus.blank_lz  = 1'b0;
    bus.dp_mask   = 8'h00;

    tick(); tick();
    check("rst_ready", {7'd0, bus.ready}, 8'd1);
    check("rst_ovf",   {7'd0, bus.ovf},   8'd0);
    check("rst_an",    bus.AN,  8'hFF);
    check("rst_seg",   bus.SEG, 8'hFF);
    rst = 1'b0;
    tick();

    do_load(14'd1234, 0, "l1234");
    wait_slot(8'hFE, 8'h99, "d1234_0");
    wait_slot(8'hFD, 8'hB0, "d1234_1");
    wait_slot(8'hFB, 8'hA4, "d1234_2");
    wait_slot(8'hF7, 8'hF9, "d1234_3");
    check("ovf_1234", {7'd0, bus.ovf}, 8'd0);

    bus.blank_lz = 1'b1;
    do_load(14'd7, 0, "l7");
    wait_slot(8'hFE, 8'hF8, "lz7_0");
    wait_slot(8'hFD, 8'hFF, "lz7_1");
    wait_slot(8'hFB, 8'hFF, "lz7_2");
    wait_slot(8'hF7, 8'hFF, "lz7_3");
    bus.blank_lz = 1'b0;
    wait_slot(8'hFD, 8'hC0, "nolz7_1");
    wait_slot(8'hFB, 8'hC0, "nolz7_2");
    wait_slot(8'hF7, 8'hC0, "nolz7_3");

    do_load(14'd12000, 0, "l12000");
    check("ovf_sat", {7'd0, bus.ovf}, 8'd1);
    wait_slot(8'hFE, 8'h90, "sat_0");
    wait_slot(8'hFD, 8'h90, "sat_1");
    wait_slot(8'hFB, 8'h90, "sat_2");
    wait_slot(8'hF7, 8'h90, "sat_3");
    do_load(14'd5, 0, "l5");
    check("ovf_clear", {7'd0, bus.ovf}, 8'd0);
    wait_slot(8'hFE, 8'h92, "d5_0");

    do_load(14'd1234, 5, "ldrop");
    wait_slot(8'hFE, 8'h99, "drop_0");
    wait_slot(8'hFD, 8'hB0, "drop_1");
    wait_slot(8'hFB, 8'hA4, "drop_2");
    wait_slot(8'hF7, 8'hF9, "drop_3");
    tick(); tick();
    check("drop_ready_idle", {7'd0, bus.ready}, 8'd1);

    bus.bin_in    = 14'd500;
    bus.bin_valid = 1'b1;
    tick();
    bus.bin_valid = 1'b0;
    for (int c = 1; c < 8; c++) tick();
    check("abort_busy", {7'd0, bus.ready}, 8'd0);
    rst = 1'b1;
    #1;
    check("abort_an",  bus.AN,  8'hFF);
    check("abort_seg", bus.SEG, 8'hFF);
    tick();
    rst = 1'b0;
    tick();
    check("abort_ready", {7'd0, bus.ready}, 8'd1);
    check("abort_ovf",   {7'd0, bus.ovf},   8'd0);
    wait_slot(8'hFE, 8'hC0, "abort_0");

    bus.dp_mask = 8'h04;
    do_load(14'd1234, 0, "ldp");
    wait_slot(8'hFB, 8'h24, "dp_2");
    wait_slot(8'hFE, 8'h99, "dp_0");
    wait_slot(8'hFD, 8'hB0, "dp_1");
    wait_slot(8'hF7, 8'hF9, "dp_3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
